// File: rtl/usb_packet_tx_pkg.sv
// Shared USB definitions: PID encodings, CRC16 constants and small helpers
// used by both the transmit and receive paths.
package types;

    typedef enum logic [3:0] {
        OUT   = 4'b0001,
        IN    = 4'b1001,
        SOF   = 4'b0101,
        SETUP = 4'b1101,
        DATA0 = 4'b0011,
        DATA1 = 4'b1011,
        DATA2 = 4'b0111,
        MDATA = 4'b1111,
        ACK   = 4'b0010,
        NAK   = 4'b1010,
        STALL = 4'b1110,
        NYET  = 4'b0110
    } pid_t;

    // Polynomial and residual are given in conventional MSB-first notation.
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

    function automatic logic [15:0] bit_rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

endpackage

// File: rtl/usb_packet_tx_crc16.sv
// Byte-wide USB CRC16 register; shared by the transmit and receive paths.
module usb_crc16
    import types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // Register is kept bit-reflected so LSB-first data shifts right and the
    // low byte is the one that goes on the wire first.
    localparam logic [15:0] POLY_REFL = bit_rev16(CRC16_POLY);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            for (int i = 0; i < 8; i++)
                crc_d = (crc_d[0] ^ data[i]) ? ((crc_d >> 1) ^ POLY_REFL) : (crc_d >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) crc_q <= CRC16_INIT;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_packet_tx.sv
// SIE packet transmitter: PID byte, optional payload from the endpoint buffer
// and CRC16, handed to the transceiver one byte per tx_ready pulse.
module usb_packet_tx
    import types::*;
#(
    parameter  int MAX_LEN = 64,
    parameter  int GAP     = 40,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    pid,
    input  logic [LW-1:0] len,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic          data_cls_q, data_cls_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] count_q, count_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          need_byte;
    logic          crc_init, crc_en;
    logic [15:0]   crc;

    usb_crc16 u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .data  (in_data),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            data_cls_q <= 1'b0;
            len_q      <= '0;
            count_q    <= '0;
            tx_data_q  <= 8'h00;
            gap_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_cls_q <= data_cls_d;
            len_q      <= len_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_cls_d = data_cls_q;
        len_d      = len_q;
        count_d    = count_q;
        tx_data_d  = tx_data_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        crc_init   = 1'b0;
        crc_en     = 1'b0;

        // Underrun abandons the packet; the host sees a bad CRC.
        if (in_ready && !in_valid) begin
            error_d   = 1'b1;
            state_d   = S_GAP;
            gap_d     = GW'(GAP - 1);
            tx_data_d = 8'h00;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d    = S_PID;
                    data_cls_d = (pid[1:0] == 2'b11);
                    len_d      = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
                    count_d    = '0;
                    crc_init   = 1'b1;
                    tx_data_d  = pid_byte(pid);
                end
                S_PID: if (tx_ready) begin
                    if (!data_cls_q) begin
                        state_d   = S_GAP;
                        gap_d     = GW'(GAP - 1);
                        tx_data_d = 8'h00;
                        done_d    = 1'b1;
                    end else if (len_q == '0) begin
                        state_d   = S_CRC_LO;
                        tx_data_d = ~crc[7:0];
                    end else begin
                        state_d   = S_DATA;
                        tx_data_d = in_data;
                        crc_en    = 1'b1;
                        count_d   = LW'(1);
                    end
                end
                S_DATA: if (tx_ready) begin
                    if (count_q == len_q) begin
                        state_d   = S_CRC_LO;
                        tx_data_d = ~crc[7:0];
                    end else begin
                        tx_data_d = in_data;
                        crc_en    = 1'b1;
                        count_d   = count_q + 1'b1;
                    end
                end
                S_CRC_LO: if (tx_ready) begin
                    state_d   = S_CRC_HI;
                    tx_data_d = ~crc[15:8];
                end
                S_CRC_HI: if (tx_ready) begin
                    state_d   = S_GAP;
                    gap_d     = GW'(GAP - 1);
                    tx_data_d = 8'h00;
                    done_d    = 1'b1;
                end
                S_GAP: begin
                    if (gap_q == '0) state_d = S_IDLE;
                    else             gap_d   = gap_q - 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_valid  = (state_q == S_PID) || (state_q == S_DATA) ||
                    (state_q == S_CRC_LO) || (state_q == S_CRC_HI);
        busy      = (state_q != S_IDLE);
        need_byte = ((state_q == S_PID) && data_cls_q && (len_q != '0)) ||
                    ((state_q == S_DATA) && (count_q != len_q));
        in_ready  = tx_ready && need_byte;
    end

    assign tx_data = tx_data_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_usb_packet_tx.sv
// Scoreboarded bench for usb_packet_tx: directed packets, a transceiver model
// pacing tx_ready, and a monitor that checks every byte and end-of-packet pulse.
module tb_usb_packet_tx;
    import types::*;

    localparam int MAX_LEN = 10;
    localparam int GAP     = 20;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    pid = 4'h0;
    logic [LW-1:0] len = '0;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy, done, error;

    int          n_chk = 0, n_fail = 0;
    logic [7:0]  exp_b[$];
    logic [1:0]  exp_e[$];   // 2'b01 = done, 2'b10 = error
    bit          fall_chk = 0, ir_seen = 0;
    int          tx_delay = 1;
    int          pay_idx = 0, pay_avail = 16, xfer_cnt = 0;
    logic [7:0]  payload [0:15];

    usb_packet_tx #(.MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .pid(pid), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .error(error)
    );

    initial forever #5 clk = ~clk;

    assign in_data  = payload[pay_idx[3:0]];
    assign in_valid = (pay_idx < pay_avail);

    // Endpoint buffer: a new packet rewinds the read pointer.
    always @(posedge clk) begin
        if (start && !busy) begin
            pay_idx  <= 0;
            xfer_cnt <= 0;
        end else if (in_ready && in_valid) begin
            pay_idx  <= pay_idx + 1;
            xfer_cnt <= xfer_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transceiver model: one-cycle tx_ready pulses, tx_delay idle cycles apart.
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (tx_ready) tx_ready = 1'b0;
            else if (tx_valid) begin
                if (wcnt >= tx_delay) begin tx_ready = 1'b1; wcnt = 0; end
                else wcnt++;
            end else wcnt = 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands over a byte or pulses.
    initial begin
        logic [7:0] eb;
        logic [1:0] ee;
        forever begin
            @(negedge clk);
            if (fall_chk) begin
                check("tx_valid_fall", {15'd0, tx_valid}, 16'd0);
                fall_chk = 0;
            end
            if (!reset && tx_valid && tx_ready) begin
                if (exp_b.size() == 0) check("unexpected_byte", {8'd0, tx_data}, 16'hFFFF);
                else begin
                    eb = exp_b.pop_front();
                    check("tx_byte", {8'd0, tx_data}, {8'd0, eb});
                    if (exp_b.size() == 0) fall_chk = 1;
                end
            end
            if (done || error) begin
                if (exp_e.size() == 0) check("unexpected_pulse", {14'd0, error, done}, 16'd0);
                else begin
                    ee = exp_e.pop_front();
                    check("end_pulse", {14'd0, error, done}, {14'd0, ee});
                end
            end
            if (in_ready) ir_seen = 1;
        end
    end

    // Bit-serial reference: MSB-first register fed LSB-first data, reflected at the end.
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c = 16'hFFFF;
        logic [15:0] r;
        logic fb;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ payload[k][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        for (int i = 0; i < 16; i++) r[i] = c[15-i];
        return r;
    endfunction

    task automatic push_data_pkt(input logic [3:0] p, input int n);
        logic [15:0] c;
        exp_b.push_back({~p, p});
        for (int k = 0; k < n; k++) exp_b.push_back(payload[k]);
        c = crc_model(n);
        exp_b.push_back(~c[7:0]);
        exp_b.push_back(~c[15:8]);
        exp_e.push_back(2'b01);
    endtask

    task automatic pulse_start(input logic [3:0] p, input logic [LW-1:0] l);
        @(posedge clk); #1;
        pid = p; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_tx_low();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!tx_valid) break;
        end
        if (tx_valid) check("tx_low_timeout", {15'd0, tx_valid}, 16'd0);
    endtask

    task automatic wait_idle(output int gcnt);
        gcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (!tx_valid) gcnt++;
        end
        if (busy) check("idle_timeout", {15'd0, busy}, 16'd0);
    endtask

    task automatic end_pkt(input string name);
        int g;
        wait_idle(g);
        check({name, "_gap"}, 16'(g), 16'(GAP));
        check({name, "_bytes_left"}, 16'(exp_b.size()), 16'd0);
        check({name, "_pulses_left"}, 16'(exp_e.size()), 16'd0);
    endtask

    initial begin
        int g;
        for (int i = 0; i < 16; i++) payload[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("rst_tx_data",  {8'd0, tx_data},   16'd0);
        check("rst_busy",     {15'd0, busy},     16'd0);
        check("rst_done",     {15'd0, done},     16'd0);
        check("rst_error",    {15'd0, error},    16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        reset = 1'b0;

        // Handshake packet: single byte, no payload fetch.
        ir_seen = 0;
        exp_b.push_back(8'hD2); exp_e.push_back(2'b01);
        pulse_start(ACK, LW'(5));
        end_pkt("ack");
        check("ack_in_ready_seen", {15'd0, ir_seen}, 16'd0);
        check("ack_xfers", 16'(xfer_cnt), 16'd0);

        // Zero-length DATA0: CRC of nothing is 0xFFFF, sent complemented.
        tx_delay = 2;
        exp_b.push_back(8'hC3); exp_b.push_back(8'h00); exp_b.push_back(8'h00);
        exp_e.push_back(2'b01);
        pulse_start(DATA0, LW'(0));
        end_pkt("data0_len0");

        // DATA1 with four bytes at the tightest tx_ready spacing.
        tx_delay = 0;
        for (int i = 0; i < 4; i++) payload[i] = 8'(i);
        push_data_pkt(DATA1, 4);
        pulse_start(DATA1, LW'(4));
        end_pkt("data1_len4");
        check("data1_xfers", 16'(xfer_cnt), 16'd4);

        // Underrun at the fourth payload byte.
        tx_delay = 1;
        for (int i = 0; i < 16; i++) payload[i] = 8'hA0 + 8'(i);
        pay_avail = 3;
        exp_b.push_back(8'hC3); exp_b.push_back(8'hA0);
        exp_b.push_back(8'hA1); exp_b.push_back(8'hA2);
        exp_e.push_back(2'b10);
        pulse_start(DATA0, LW'(8));
        end_pkt("underrun");
        pay_avail = 16;

        // start while busy (mid-packet and during the gap) is ignored.
        tx_delay = 3;
        exp_b.push_back(8'h5A); exp_e.push_back(2'b01);
        pulse_start(NAK, LW'(0));
        pulse_start(STALL, LW'(0));
        wait_tx_low();
        pulse_start(STALL, LW'(0));
        wait_idle(g);
        check("ignore_bytes_left", 16'(exp_b.size()), 16'd0);
        check("ignore_pulses_left", 16'(exp_e.size()), 16'd0);
        exp_b.push_back(8'h1E); exp_e.push_back(2'b01);
        pulse_start(STALL, LW'(0));
        end_pkt("stall_after_idle");

        // Over-long length is clamped to MAX_LEN.
        tx_delay = 1;
        for (int i = 0; i < 16; i++) payload[i] = 8'(i * 17 + 3);
        push_data_pkt(DATA0, MAX_LEN);
        pulse_start(DATA0, LW'(12));
        end_pkt("clamp");
        check("clamp_xfers", 16'(xfer_cnt), 16'(MAX_LEN));

        // Reset in the middle of the payload.
        push_data_pkt(DATA1, 8);
        pulse_start(DATA1, LW'(8));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (xfer_cnt >= 2) break;
        end
        check("midrst_reached", {15'd0, (xfer_cnt >= 2)}, 16'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("midrst_busy",     {15'd0, busy},     16'd0);
        check("midrst_in_ready", {15'd0, in_ready}, 16'd0);
        check("midrst_tx_data",  {8'd0, tx_data},   16'd0);
        reset = 1'b0;
        exp_b.delete(); exp_e.delete(); fall_chk = 0;
        exp_b.push_back(8'hC3); exp_b.push_back(8'h00); exp_b.push_back(8'h00);
        exp_e.push_back(2'b01);
        pulse_start(DATA0, LW'(0));
        end_pkt("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/usb_packet_tx.md
# usb_packet_tx

SIE-side packet transmitter for the USB device path. Accepts a send request (PID plus payload length), fetches payload bytes from the endpoint buffer, and generates the PID byte, payload and CRC16. It drives the transceiver's byte-level TX interface (`tx_data`/`tx_valid`/`tx_ready`). It is the initiating end of the interface that the transceiver's TX path serializes onto D+/D- with SYNC and EOP.

## Interface
Parameters:
- `MAX_LEN`, 64: maximum payload bytes; length width `LW = $clog2(MAX_LEN+1)`.
- `GAP`, 40: clk cycles `busy` stays high after `tx_valid` falls, covering the last byte, EOP and turnaround.

Ports (clock and reset first):
- `clk` in 1: system clock (24 MHz); single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: packet request; sampled only in IDLE.
- `pid` in 4: PID sampled with `start`.
- `len` in LW: payload length sampled with `start`; used only for DATA-class PIDs.
- `in_data` in 8: payload byte from endpoint buffer.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte consumed this cycle; transfer occurs when `in_ready & in_valid`.
- `tx_data` out 8: byte to transceiver.
- `tx_valid` out 1: rise starts SYNC, high while sending, fall triggers EOP.
- `tx_ready` in 1: one-cycle pulse; current `tx_data` has been taken by the transceiver.
- `busy` out 1: packet in progress or gap running.
- `done` out 1: one-cycle pulse at normal packet end.
- `error` out 1: one-cycle pulse on payload underrun.

## Operation
States:
- IDLE: accepts `start`.
- PID: sends the PID byte.
- DATA: sends payload bytes.
- CRC_LO, CRC_HI: send the two CRC bytes.
- GAP: post-packet hold-off.

PID and packet class:
- PID byte is `{~pid, pid}`; ACK = 0xD2, NAK = 0x5A, STALL = 0x1E, DATA0 = 0xC3, DATA1 = 0x4B.
- `pid[1:0]==2'b11` is DATA class: PID, then `len` payload bytes, then CRC16.
- Any other `pid` is sent as PID only; `len` is ignored.

Transitions:
- IDLE, `start=1` → PID. PID, `len` and class are latched; the CRC is initialised to 0xFFFF; the byte counter is cleared.
- PID, `tx_ready`:
  - PID-only → GAP.
  - DATA class with `len==0` → CRC_LO.
  - Otherwise → DATA, fetching the first payload byte.
- DATA, `tx_ready`: counter increments. When `count==len` → CRC_LO; otherwise fetch the next byte.
- CRC_LO, `tx_ready` → CRC_HI. CRC_HI, `tx_ready` → GAP.
- GAP: counts `GAP` cycles, then → IDLE.

Payload fetch:
- `in_ready = tx_ready & (next byte required)`. This is combinational and appears in the same cycle as the `tx_ready` pulse.
- If `in_valid=0` while `in_ready=1` (underrun): `error` pulses, `tx_valid` drops, no `done`, → GAP. The truncated packet fails CRC at the host.

CRC16:
- Polynomial 0x8005 (x^16+x^15+x^2+1), init 0xFFFF.
- Bits processed LSB first over payload bytes only.
- Transmitted complemented, low byte first: CRC_LO byte = `~crc[7:0]`, CRC_HI byte = `~crc[15:8]`.

Boundaries:
- `start` while `busy` is ignored.
- `len > MAX_LEN` is clamped to `MAX_LEN`.
- `tx_ready` in IDLE or GAP is ignored.
- Reset mid-packet: all outputs go to their reset values at the next edge. No `done`, no `error`.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0x00`, `busy=0`, `done=0`, `error=0`, `in_ready=0`; state IDLE.
- `start` in IDLE at edge t: `tx_valid=1`, `tx_data`=PID byte and `busy=1` from t+1.
- `tx_data` is registered and holds until `tx_ready`. The next byte appears at the edge after the `tx_ready` pulse, and `tx_valid` stays high between bytes.
- Last byte's `tx_ready` at cycle c: `tx_valid=0` from c+1, and `done=1` for cycle c+1 only.
- `busy` stays high through the GAP state and falls after `GAP` cycles; the earliest next `start` is accepted once `busy=0`.
- Back-to-back `tx_ready` pulses are not expected. A minimum of one cycle between pulses must be handled correctly.

## Structure
- Shared package `types`:
  - `pid_t` enum (OUT, IN, SOF, SETUP, DATA0, DATA1, DATA2, MDATA, ACK, NAK, STALL, NYET).
  - `CRC16_POLY = 16'h8005`, `CRC16_INIT = 16'hFFFF`, `CRC16_RESIDUAL = 16'h800D`.
- State enum is local to the block.
- One sub-module, `usb_crc16`: byte-wide CRC update with `init`, `en`, `data[7:0]` inputs and `crc[15:0]` register. The receive-side CRC check reuses it.

## Test plan
- `start`, `pid=ACK` → single byte 0xD2, then `tx_valid` falls one cycle after its `tx_ready`; `done` pulses; `in_ready` never asserted.
- `start`, `pid=DATA0`, `len=0` → bytes C3, 00, 00; `done` pulses once.
- `pid=DATA1`, `len=4`, payload 00 01 02 03 → bytes 4B 00 01 02 03 followed by two CRC bytes equal to the bit-serial reference model; exactly 4 `in_ready & in_valid` transfers.
- DATA0 with `len=8`, `in_valid` dropped at byte 3 → `error` pulse, `tx_valid` low next cycle, no `done`, `busy` low after `GAP` cycles.
- `start` pulsed during a packet and during GAP → ignored; first packet unchanged; next `start` accepted only after `busy=0`.
- `reset` asserted mid-payload → next cycle `tx_valid=0`, `busy=0`; a following DATA0 `len=0` packet yields C3 00 00.
